// File: rtl/bffma_pkg.sv
// rtl/bffma_pkg.sv - shared types and constants for the bfloat16 FMA arbiter
// Purpose: operand width, shadow-pipeline stage type, bf16 constants, small helpers.
// Ports: none (package).
package bffma_pkg;

  localparam int BF16_W = 16;
  // Tag field is sized for the largest supported requester count (8).
  localparam int NREQ_MAX = 8;
  localparam int TAG_W = $clog2(NREQ_MAX);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } shadow_t;

  localparam logic [BF16_W-1:0] BF16_ZERO  = 16'h0000;
  localparam logic [BF16_W-1:0] BF16_ONE   = 16'h3F80;
  localparam logic [BF16_W-1:0] BF16_TWO   = 16'h4000;
  localparam logic [BF16_W-1:0] BF16_THREE = 16'h4040;
  localparam logic [BF16_W-1:0] BF16_FIVE  = 16'h40A0;

  // Modulo-n increment without a divider.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/bffma_fma_arb_if.sv
// rtl/bffma_fma_arb_if.sv - request/FMA/response bus for the FMA arbiter
// Purpose: groups requester handshakes, FMA issue/result and response FIFO signals.
// Ports: slave modport = arbiter side, master modport = requesters + FMA side.
interface bffma_fma_arb_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 16
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic [NREQ*DATA_W-1:0] req_c;
  logic                   fma_in_valid;
  logic [DATA_W-1:0]      fma_a;
  logic [DATA_W-1:0]      fma_b;
  logic [DATA_W-1:0]      fma_c;
  logic                   fma_res_valid;
  logic [DATA_W-1:0]      fma_res;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [NREQ*DATA_W-1:0] rsp_data;
  logic                   err;

  modport slave (
    input  req_valid, req_a, req_b, req_c, fma_res_valid, fma_res, rsp_ready,
    output req_ready, fma_in_valid, fma_a, fma_b, fma_c, rsp_valid, rsp_data, err
  );

  modport master (
    output req_valid, req_a, req_b, req_c, fma_res_valid, fma_res, rsp_ready,
    input  req_ready, fma_in_valid, fma_a, fma_b, fma_c, rsp_valid, rsp_data, err
  );
endinterface

// File: rtl/bffma_rsp_fifo.sv
// rtl/bffma_rsp_fifo.sv - show-ahead response FIFO, one per requester
// Purpose: buffers retired FMA results until the requester pops them.
// Ports: clk, rst (sync, active-high), wr_en/wr_data push, rd_en pop,
//        rd_data head (zero when empty), rd_valid non-empty.
module bffma_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign do_rd = rd_en && !empty;
  // Upstream credits keep writes off a full FIFO; the guard only protects contents.
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bffma_fma_arb.sv
// rtl/bffma_fma_arb.sv - round-robin arbiter sharing one pipelined bf16 FMA
// Purpose: credit-gated round-robin issue into a fixed-latency FMA, tag tracking
//          through a shadow pipeline, and steering of results into per-requester FIFOs.
// Ports: clk, rst (sync, active-high); bus (slave modport): req_* handshakes and
//        operands, fma_* issue/result, rsp_* FIFO heads/pops, sticky err.
// Config: define BFFMA_ARB_PRIO_EN to give requester 0 strict priority.
module bffma_fma_arb
  import bffma_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 16,
  parameter int FMA_LAT   = 3,
  parameter int RSP_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  bffma_fma_arb_if.slave   bus
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int CRD_W = $clog2(RSP_DEPTH + 1);

  logic [IDX_W-1:0]  ptr_q, ptr_d, grant_idx;
  logic              grant_any, grant_prio, gnt;
  logic [NREQ-1:0]   elig, grant_oh, pop, fifo_wr;
  logic [CRD_W-1:0]  credit_q [NREQ];
  logic [CRD_W-1:0]  credit_d [NREQ];
  logic              fma_in_valid_q, fma_in_valid_d;
  logic [DATA_W-1:0] fma_a_q, fma_a_d, fma_b_q, fma_b_d, fma_c_q, fma_c_d;
  shadow_t           shadow_q [FMA_LAT+1];
  shadow_t           shadow_d [FMA_LAT+1];
  shadow_t           retire;
  logic              err_q, err_d;
  logic [NREQ-1:0]        rsp_valid_w;
  logic [NREQ*DATA_W-1:0] rsp_data_w;

  // A requester may win only if its FIFO can hold every result already owed to it.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = bus.req_valid[i] && (credit_q[i] < CRD_W'(RSP_DEPTH));
    end
  end

  // Scan offsets from the far end down so the smallest offset from ptr wins.
  always_comb begin
    int idx;
    idx        = 0;
    grant_any  = 1'b0;
    grant_prio = 1'b0;
    grant_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (elig[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
`ifdef BFFMA_ARB_PRIO_EN
    if (elig[0]) begin
      grant_any  = 1'b1;
      grant_prio = 1'b1;
      grant_idx  = '0;
    end
`endif
  end

  assign gnt = grant_any && !rst;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = gnt && (grant_idx == IDX_W'(i));
      pop[i]      = rsp_valid_w[i] && bus.rsp_ready[i];
    end
  end

  assign retire = shadow_q[FMA_LAT];

  always_comb begin
    ptr_d          = ptr_q;
    fma_in_valid_d = gnt;
    fma_a_d        = fma_a_q;
    fma_b_d        = fma_b_q;
    fma_c_d        = fma_c_q;
    err_d          = err_q;
    shadow_d[0].valid = gnt;
    shadow_d[0].tag   = TAG_W'(grant_idx);
    for (int s = 1; s <= FMA_LAT; s++) shadow_d[s] = shadow_q[s-1];

    if (gnt) begin
      // A strict-priority win by requester 0 leaves the rotation where it was.
      if (!grant_prio) ptr_d = IDX_W'(wrap_inc(int'(grant_idx), NREQ));
      fma_a_d = bus.req_a[grant_idx*DATA_W +: DATA_W];
      fma_b_d = bus.req_b[grant_idx*DATA_W +: DATA_W];
      fma_c_d = bus.req_c[grant_idx*DATA_W +: DATA_W];
    end

    if (bus.fma_res_valid != retire.valid) err_d = 1'b1;

    for (int i = 0; i < NREQ; i++) begin
      fifo_wr[i]  = retire.valid && (retire.tag == TAG_W'(i));
      credit_d[i] = credit_q[i];
      if (grant_oh[i] && !pop[i]) begin
        credit_d[i] = credit_q[i] + 1'b1;
      end else if (!grant_oh[i] && pop[i]) begin
        credit_d[i] = credit_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      fma_in_valid_q <= 1'b0;
      fma_a_q        <= '0;
      fma_b_q        <= '0;
      fma_c_q        <= '0;
      err_q          <= 1'b0;
      for (int s = 0; s <= FMA_LAT; s++) shadow_q[s] <= '0;
      for (int i = 0; i < NREQ; i++) credit_q[i] <= '0;
    end else begin
      ptr_q          <= ptr_d;
      fma_in_valid_q <= fma_in_valid_d;
      fma_a_q        <= fma_a_d;
      fma_b_q        <= fma_b_d;
      fma_c_q        <= fma_c_d;
      err_q          <= err_d;
      shadow_q       <= shadow_d;
      credit_q       <= credit_d;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    bffma_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (DATA_W)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (fifo_wr[i]),
      .wr_data  (bus.fma_res),
      .rd_en    (bus.rsp_ready[i]),
      .rd_data  (rsp_data_w[i*DATA_W +: DATA_W]),
      .rd_valid (rsp_valid_w[i])
    );
  end

  assign bus.req_ready    = grant_oh;
  assign bus.fma_in_valid = fma_in_valid_q;
  assign bus.fma_a        = fma_a_q;
  assign bus.fma_b        = fma_b_q;
  assign bus.fma_c        = fma_c_q;
  assign bus.rsp_valid    = rsp_valid_w;
  assign bus.rsp_data     = rsp_data_w;
  assign bus.err          = err_q;

endmodule
